// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: width default,
// funct3 encodings and the controller state type.
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_sign_cond.sv
// Operand sign conditioning for RV32M: magnitudes and sign flags at accept,
// plus the conditional negate applied to the raw product/quotient/remainder.
module muldiv_sign_cond
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
)
(
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   op_a,
    input  logic [XLEN-1:0]   op_b,
    output logic [XLEN-1:0]   mag_a,
    output logic [XLEN-1:0]   mag_b,
    output logic              neg_a,
    output logic              neg_b,
    input  logic [2*XLEN-1:0] fix_value,
    input  logic              fix_negate,
    output logic [2*XLEN-1:0] fix_result
);

    logic signed_a;
    logic signed_b;

    // MUL is sign-agnostic in its low half, so it is treated as unsigned.
    always_comb begin
        signed_a   = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                     (funct3 == F3_DIV)  || (funct3 == F3_REM);
        signed_b   = (funct3 == F3_MULH) || (funct3 == F3_DIV) ||
                     (funct3 == F3_REM);
        neg_a      = signed_a && op_a[XLEN-1];
        neg_b      = signed_b && op_b[XLEN-1];
        mag_a      = neg_a ? -op_a : op_a;
        mag_b      = neg_b ? -op_b : op_b;
        fix_result = fix_negate ? -fix_value : fix_value;
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage (radix-2, XLEN steps).
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier; division stays iterative.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);

    muldiv_state_t     state;
    logic [2:0]        op_q;
    logic              sign_a_q;
    logic              sign_b_q;
    logic [XLEN-1:0]   operand_q;
    logic [2*XLEN-1:0] acc;
    logic [XLEN:0]     rem;
    logic [CNT_W-1:0]  count;

    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              neg_a;
    logic              neg_b;
    logic [2*XLEN-1:0] fix_value;
    logic              fix_negate;
    logic [2*XLEN-1:0] fix_result;
    logic [XLEN-1:0]   result_next;

    logic              accept;
    logic              div_zero;
    logic              div_ovf;
    logic [XLEN-1:0]   special_value;

    logic [XLEN:0]     mul_sum;
    logic [XLEN+1:0]   div_shift;
    logic [XLEN+1:0]   div_diff;

    muldiv_sign_cond #(.XLEN(XLEN)) u_sign_cond (
        .funct3     (funct3),
        .op_a       (op_a),
        .op_b       (op_b),
        .mag_a      (mag_a),
        .mag_b      (mag_b),
        .neg_a      (neg_a),
        .neg_b      (neg_b),
        .fix_value  (fix_value),
        .fix_negate (fix_negate),
        .fix_result (fix_result)
    );

    assign accept = start && !flush && ((state == IDLE) || (state == DONE));

    // Divide-by-zero and signed overflow bypass the datapath entirely.
    always_comb begin
        div_zero      = funct3[2] && (op_b == '0);
        div_ovf       = funct3[2] && !funct3[0] &&
                        (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
        special_value = op_a;
        if (div_zero) begin
            special_value = funct3[1] ? op_a : '1;
        end else if (funct3[1]) begin
            special_value = '0;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [XLEN:0]     fast_a;
    logic signed [XLEN:0]     fast_b;
    logic signed [2*XLEN-1:0] fast_prod;

    assign fast_a    = {neg_a, op_a};
    assign fast_b    = {neg_b, op_b};
    assign fast_prod = (2*XLEN)'(fast_a) * (2*XLEN)'(fast_b);
`endif

    // Multiplier sits in the low half of acc and shifts out as the product shifts in;
    // the divider shifts the dividend out of acc[XLEN-1] and the quotient in at bit 0.
    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? operand_q : '0)};
        div_shift = {rem, acc[XLEN-1]};
        div_diff  = div_shift - {2'b00, operand_q};
    end

    always_comb begin
        fix_value  = acc;
        fix_negate = sign_a_q ^ sign_b_q;
        if (op_q[2]) begin
            if (op_q[1]) begin
                fix_value  = {{XLEN{1'b0}}, rem[XLEN-1:0]};
                fix_negate = sign_a_q;
            end else begin
                fix_value  = {{XLEN{1'b0}}, acc[XLEN-1:0]};
            end
        end
        result_next = ((op_q == F3_MUL) || op_q[2]) ? fix_result[XLEN-1:0]
                                                    : fix_result[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            op_q      <= F3_MUL;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            operand_q <= '0;
            acc       <= '0;
            rem       <= '0;
            count     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (accept) begin
                        op_q      <= funct3;
                        sign_a_q  <= neg_a;
                        sign_b_q  <= neg_b;
                        operand_q <= funct3[2] ? mag_b : mag_a;
                        acc       <= {{XLEN{1'b0}}, (funct3[2] ? mag_a : mag_b)};
                        rem       <= '0;
                        count     <= '0;
                        if (div_zero || div_ovf) begin
                            result <= special_value;
                            done   <= 1'b1;
                            state  <= DONE;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (!funct3[2]) begin
                            acc      <= fast_prod;
                            sign_a_q <= 1'b0;
                            sign_b_q <= 1'b0;
                            busy     <= 1'b1;
                            state    <= FIX;
`endif
                        end else begin
                            busy  <= 1'b1;
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (op_q[2]) begin
                            acc[XLEN-1:0] <= {acc[XLEN-2:0], ~div_diff[XLEN+1]};
                            rem           <= div_diff[XLEN+1] ? div_shift[XLEN:0]
                                                              : div_diff[XLEN:0];
                        end else begin
                            acc <= {mul_sum, acc[XLEN-1:1]};
                        end
                        count <= count + CNT_W'(1);
                        if (count == CNT_W'(XLEN-1)) begin
                            state <= FIX;
                        end
                    end
                end
                FIX: begin
                    busy <= 1'b0;
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        result <= result_next;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: a driver pushes expected result and done cycle,
// an independent monitor pops on every done pulse and compares.
module tb_ex_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        int          due;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc;
    int   checks;
    int   errors;
    int   dones_seen;

    ex_muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Arithmetic reference written directly from the RV32M definitions.
    function automatic logic [31:0] refModel(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ua;
        longint      ub;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = 64'(0);
        case (f3)
            F3_MUL:    begin p = 64'(ua * ub); return p[31:0];  end
            F3_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
            F3_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
            F3_MULHU:  begin p = 64'(ua * ub); return p[63:32]; end
            F3_DIV: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = 64'(sa / sb);
                return p[31:0];
            end
            F3_DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            F3_REM: begin
                if (b == 32'd0) return a;
                if (ovf) return 32'd0;
                p = 64'(sa % sb);
                return p[31:0];
            end
            default:   return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int latFor(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && (b == 32'd0)) return 1;
        if ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!f3[2]) return 2;
`endif
        return 34;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    // Called at a negedge; returns at the negedge of cycle 1.
    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b, input bit track);
        exp_t e;
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        if (track) begin
            e.res = refModel(f3, a, b);
            e.due = cyc + latFor(f3, a, b);
            sb_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        op_a  = $urandom;
        op_b  = $urandom;
    endtask

    task automatic waitDone();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: actual=no done after %0d cycles required=done", n);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            dones_seen++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: actual=done 1 result=0x%08h required=no done", result);
            end else begin
                mon_e = sb_q.pop_front();
                checkOutput("result", result, mon_e.res);
                checkOutput("done_cycle", 32'(cyc), 32'(mon_e.due));
            end
        end
    end

    initial begin
        int          bad;
        int          snap;
        int          lat;
        logic [31:0] prev;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f3;

        checks     = 0;
        errors     = 0;
        dones_seen = 0;
        cyc        = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        flush      = 1'b0;
        funct3     = 3'd0;
        op_a       = 32'd0;
        op_b       = 32'd0;

        repeat (3) @(negedge clk);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_result", result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] MUL latency and busy window");
        lat = latFor(F3_MUL, 32'd7, 32'hFFFF_FFFD);
        applyStimulus(F3_MUL, 32'd7, 32'hFFFF_FFFD, 1);
        bad = 0;
        for (int k = 1; k < lat; k++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            @(negedge clk);
        end
        checkOutput("busy_window", 32'(bad), 32'd0);
        checkOutput("done_pulse", {31'd0, done}, 32'd1);
        checkOutput("busy_at_done", {31'd0, busy}, 32'd0);
        @(negedge clk);
        checkOutput("done_one_cycle", {31'd0, done}, 32'd0);
        checkOutput("result_held", result, 32'hFFFF_FFEB);

        $display("[TB] directed vectors, issued back-to-back");
        applyStimulus(F3_MULH,   32'h8000_0000, 32'h8000_0000, 1); waitDone();
        applyStimulus(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1); waitDone();
        applyStimulus(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1); waitDone();
        applyStimulus(F3_DIV,    32'hFFFF_FFF9, 32'd2,         1); waitDone();
        applyStimulus(F3_REM,    32'hFFFF_FFF9, 32'd2,         1); waitDone();
        applyStimulus(F3_DIVU,   32'd100,       32'd7,         1); waitDone();
        applyStimulus(F3_REMU,   32'd100,       32'd7,         1); waitDone();
        applyStimulus(F3_DIVU,   32'd5,         32'd0,         1); waitDone();
        applyStimulus(F3_REM,    32'd5,         32'd0,         1); waitDone();
        applyStimulus(F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 1); waitDone();
        applyStimulus(F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 1); waitDone();
        @(negedge clk);

        $display("[TB] flush mid-divide");
        prev = result;
        applyStimulus(F3_DIV, 32'd12345, 32'd17, 0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush_busy", {31'd0, busy}, 32'd0);
        checkOutput("flush_done", {31'd0, done}, 32'd0);
        checkOutput("flush_result", result, prev);
        @(negedge clk);
        applyStimulus(F3_DIVU, 32'd100, 32'd7, 1);
        waitDone();
        @(negedge clk);

        $display("[TB] flush and start together");
        funct3 = F3_DIVU;
        op_a   = 32'd9;
        op_b   = 32'd0;
        start  = 1'b1;
        flush  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        checkOutput("flush_start_busy", {31'd0, busy}, 32'd0);
        checkOutput("flush_start_done", {31'd0, done}, 32'd0);
        repeat (3) @(negedge clk);

        $display("[TB] randomized operations");
        for (int i = 0; i < 48; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
                3: begin a = -32'($urandom_range(0, 300)); b = -32'($urandom_range(1, 20)); end
                default: ;
            endcase
            applyStimulus(f3, a, b, 1);
            waitDone();
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        $display("[TB] back-to-back then reset mid-operation");
        applyStimulus(F3_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 1);
        waitDone();
        applyStimulus(F3_DIV, 32'hFFFF_0000, 32'd3, 1);
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        sb_q.delete();
        snap = dones_seen;
        #1;
        checkOutput("async_reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("async_reset_done", {31'd0, done}, 32'd0);
        checkOutput("async_reset_result", result, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("no_done_after_reset", 32'(dones_seen - snap), 32'd0);
        checkOutput("scoreboard_drain", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
